// File: rtl/deb_uart_tx_pkg.sv
// Shared types and defaults for the debug-port UART transmitter.
package deb_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int BAUD_DIV_DEFAULT   = 434;
    localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/deb_byte_fifo.sv
// Byte FIFO between change detection and the transmitter.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module deb_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/deb_uart_tx.sv
// Streams every change of the debug byte out as an 8N1 UART frame, LSB first.
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low)
// DATA  | eight data bits, shift[0] on the line
// STOP  | stop bit (high)
module deb_uart_tx
    import deb_uart_tx_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] deb_in,
    input  logic       ovf_clr,
    output logic       txd,
    output logic       busy,
    output logic       overflow
);

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

    tx_state_t                     state;
    logic [7:0]                    deb_q;
    logic [7:0]                    shift;
    logic [7:0]                    fifo_dout;
    logic [15:0]                   baud_cnt;
    logic [2:0]                    bit_cnt;
    logic                          change;
    logic                          pop;
    logic                          drop;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   level;

    assign change = (deb_in != deb_q);
    assign pop    = (state == IDLE) && !fifo_empty;
    assign drop   = change && fifo_full && !pop;
    assign busy   = (state != IDLE) || (level != '0);

    deb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (change),
        .pop     (pop),
        .din     (deb_in),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q    <= 8'h00;
            overflow <= 1'b0;
        end else begin
            deb_q <= deb_in;
            // A fresh drop wins over a clear in the same cycle.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift    <= fifo_dout;
                        txd      <= 1'b0;
                        baud_cnt <= BAUD_RELOAD;
                        bit_cnt  <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        txd      <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deb_uart_tx.sv
// Directed bench for deb_uart_tx with BAUD_DIV=4, FIFO_DEPTH=4.
module tb_deb_uart_tx;

    localparam int BAUD  = 4;
    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] deb_in  = 8'h00;
    logic       txd;
    logic       busy;
    logic       overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    deb_uart_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .deb_in   (deb_in),
        .ovf_clr  (ovf_clr),
        .txd      (txd),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Expected txd per cycle from the falling start edge: 4 cycles per bit.
    function automatic logic [39:0] exp_wave(input logic [7:0] d);
        logic [9:0]  bits;
        logic [39:0] w;
        bits = {1'b1, d, 1'b0};
        for (int c = 0; c < 40; c++) w[c] = bits[c / 4];
        return w;
    endfunction

    // Waits (bounded) for a start bit, then records txd on every negedge of the frame.
    task automatic recv_frame(input int limit, output logic [39:0] wave,
                              output int wait_cycles, output bit timeout);
        timeout     = 1'b1;
        wait_cycles = 0;
        wave        = '1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                wait_cycles = i + 1;
                timeout     = 1'b0;
                break;
            end
        end
        if (!timeout) begin
            wave[0] = 1'b0;
            for (int c = 1; c < 40; c++) begin
                @(negedge clk);
                wave[c] = txd;
            end
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        deb_in  = 8'h00;
        ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        deb_in  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b expected 1", txd); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        tests_run++;
        if (dut.level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", dut.level); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_frame();
        logic [39:0] wave;
        int          w;
        bit          to;
        int          bad;
        apply_reset();
        deb_in = 8'hA5;
        recv_frame(20, wave, w, to);
        tests_run++;
        if (to || wave !== exp_wave(8'hA5)) begin
            tests_failed++;
            $display("FAIL a5_frame: wave got %h expected %h (timeout=%0d)", wave, exp_wave(8'hA5), to);
        end
        tests_run++;
        if (w !== 3) begin tests_failed++; $display("FAIL a5_latency: got %0d expected 3", w); end
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL hold_quiet: %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  exp_b [3] = '{8'h11, 8'h22, 8'h33};
        logic [39:0] wave;
        int          w;
        bit          to;
        apply_reset();
        fork
            begin
                deb_in = 8'h11;
                @(posedge clk); #1 deb_in = 8'h22;
                @(posedge clk); #1 deb_in = 8'h33;
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    recv_frame(20, wave, w, to);
                    tests_run++;
                    if (to || wave !== exp_wave(exp_b[k])) begin
                        tests_failed++;
                        $display("FAIL b2b_frame%0d: wave got %h expected %h", k, wave, exp_wave(exp_b[k]));
                    end
                    tests_run++;
                    if (w !== ((k == 0) ? 3 : 2)) begin
                        tests_failed++;
                        $display("FAIL b2b_gap%0d: got %0d expected %0d", k, w, (k == 0) ? 3 : 2);
                    end
                end
            end
        join
        recv_frame(60, wave, w, to);
        tests_run++;
        if (!to) begin tests_failed++; $display("FAIL b2b_extra: got frame %h expected none", wave); end
    endtask

    task automatic test_overflow();
        logic [39:0] wave;
        int          w;
        bit          to;
        apply_reset();
        fork
            begin
                deb_in = 8'h01;
                repeat (3) @(posedge clk);
                #1;
                for (int v = 2; v <= 7; v++) begin
                    deb_in = 8'(v);
                    @(posedge clk);
                    #1;
                end
                tests_run++;
                if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %b expected 1", overflow); end
                tests_run++;
                if (dut.level !== 3'd4) begin tests_failed++; $display("FAIL ovf_level: got %0d expected 4", dut.level); end
                ovf_clr = 1'b1;
                deb_in  = 8'h08;
                @(posedge clk);
                #1 ovf_clr = 1'b0;
                tests_run++;
                if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_clr_vs_drop: got %b expected 1", overflow); end
                ovf_clr = 1'b1;
                @(posedge clk);
                #1 ovf_clr = 1'b0;
                tests_run++;
                if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
            end
            begin
                recv_frame(20, wave, w, to);
                tests_run++;
                if (to || wave !== exp_wave(8'h01) || w !== 3) begin
                    tests_failed++;
                    $display("FAIL ovf_frame0: wave got %h expected %h gap %0d", wave, exp_wave(8'h01), w);
                end
            end
        join
        for (int v = 2; v <= 5; v++) begin
            recv_frame(20, wave, w, to);
            tests_run++;
            if (to || wave !== exp_wave(8'(v)) || w !== 2) begin
                tests_failed++;
                $display("FAIL ovf_frame%0d: wave got %h expected %h gap %0d expected 2", v, wave, exp_wave(8'(v)), w);
            end
        end
        recv_frame(60, wave, w, to);
        tests_run++;
        if (!to || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_dropped_sent: timeout %0d busy %b expected timeout 1 busy 0", to, busy);
        end
    endtask

    task automatic test_full_pop_push();
        logic [39:0] wave;
        int          w;
        bit          to;
        apply_reset();
        fork
            begin
                deb_in = 8'h01;
                for (int c = 1; c <= 43; c++) begin
                    @(posedge clk);
                    #1;
                    case (c)
                        3:  deb_in = 8'h02;
                        4:  deb_in = 8'h03;
                        5:  deb_in = 8'h04;
                        6:  deb_in = 8'h05;
                        42: deb_in = 8'h06;
                        default: ;
                    endcase
                    if (c == 42) begin
                        tests_run++;
                        if (dut.level !== 3'd4) begin tests_failed++; $display("FAIL fpp_full_before: got %0d expected 4", dut.level); end
                    end
                    if (c == 43) begin
                        tests_run++;
                        if (dut.level !== 3'd4) begin tests_failed++; $display("FAIL fpp_level: got %0d expected 4", dut.level); end
                        tests_run++;
                        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fpp_overflow: got %b expected 0", overflow); end
                    end
                end
            end
            begin
                for (int k = 1; k <= 6; k++) begin
                    recv_frame(20, wave, w, to);
                    tests_run++;
                    if (to || wave !== exp_wave(8'(k)) || w !== ((k == 1) ? 3 : 2)) begin
                        tests_failed++;
                        $display("FAIL fpp_frame%0d: wave got %h expected %h gap %0d", k, wave, exp_wave(8'(k)), w);
                    end
                end
            end
        join
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] wave;
        int          w;
        bit          to;
        apply_reset();
        deb_in = 8'h5A;
        repeat (9) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1 || txd !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_pre: busy %b txd %b expected busy 1 txd 0", busy, txd);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async: txd %b busy %b expected txd 1 busy 0", txd, busy);
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        recv_frame(20, wave, w, to);
        tests_run++;
        if (to || wave !== exp_wave(8'h5A) || w !== 3) begin
            tests_failed++;
            $display("FAIL rst_resend: wave got %h expected %h gap %0d expected 3", wave, exp_wave(8'h5A), w);
        end
        recv_frame(60, wave, w, to);
        tests_run++;
        if (!to) begin tests_failed++; $display("FAIL rst_extra: got frame %h expected none", wave); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_full_pop_push();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/deb_uart_tx.md
DEB_UART_TX -- requirements
Module: deb_uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 434, clock cycles per UART bit (434 gives 115200 baud at 50 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries buffered between change detection and transmitter; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 deb_in  input  8  debug byte from the debug PIO output port, synchronous to clk.
REQ-006 ovf_clr  input  1  single-cycle pulse that clears the overflow flag.
REQ-007 txd  output  1  UART serial output: 8N1, LSB first, idle high.
REQ-008 busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-009 overflow  output  1  sticky flag: a detected change was dropped because the FIFO was full.

Function
REQ-010 The block SHALL hold deb_q, a register of deb_in updated every cycle; a change SHALL be detected in any cycle where deb_in != deb_q.
REQ-011 On a detected change, the current deb_in SHALL be pushed into the FIFO on the same edge that updates deb_q; each change pushes exactly one byte.
REQ-012 FIFO full with a detected change and no pop that cycle: the byte SHALL be dropped, FIFO contents unchanged, overflow set on that edge.
REQ-013 FIFO full with a detected change and a pop in the same cycle: the push SHALL be accepted and the level SHALL stay FIFO_DEPTH.
REQ-014 ovf_clr SHALL clear overflow; if ovf_clr and a new drop occur in the same cycle, overflow SHALL remain set.
REQ-015 The FIFO SHALL be first-in first-out; read and write pointers wrap modulo FIFO_DEPTH; the level counter is clog2(FIFO_DEPTH)+1 bits wide.
REQ-016 The transmitter FSM states SHALL be IDLE, START, DATA and STOP.
REQ-017 IDLE with the FIFO non-empty: on the next edge the FSM SHALL pop the head byte into the shift register, drive txd low, load the baud counter with BAUD_DIV-1, and go to START.
REQ-018 An empty FIFO SHALL NOT be popped; a byte pushed into an empty FIFO is popped no earlier than the following edge (two edges from the change to txd falling).
REQ-019 The baud counter SHALL decrement each cycle; when it is 0 the bit period ends and the counter reloads with BAUD_DIV-1.
REQ-020 START -> DATA at the end of its bit period; txd = shift[0].
REQ-021 DATA: shift right at the end of each bit period; after 8 data bits go to STOP with txd high.
REQ-022 STOP: txd high for BAUD_DIV cycles, then IDLE.
REQ-023 Each frame SHALL be exactly 10*BAUD_DIV cycles from txd falling to the return to IDLE; back-to-back frames SHALL be separated by exactly one IDLE cycle.
REQ-024 txd SHALL be driven from a register (glitch-free); busy = (state != IDLE) | (level != 0).
REQ-025 Changes on deb_in during a frame SHALL NOT affect the frame in flight.

Reset
REQ-026 While reset_n is low: deb_q = 8'h00, FIFO empty with pointers 0, state IDLE, baud counter 0, shift register 0, txd = 1, overflow = 0, busy = 0.
REQ-027 A reset asserted mid-frame SHALL abort the frame immediately, drive txd high, and discard FIFO contents; no partial frame resumes.
REQ-028 After reset release, a nonzero deb_in SHALL be detected as a change against deb_q = 0 and transmitted.

Structure
REQ-029 The shared package SHALL hold the FSM state enum and the BAUD_DIV_DEFAULT and FIFO_DEPTH_DEFAULT constants.
REQ-030 The FIFO SHALL be the sub-module deb_byte_fifo (push, pop, din, dout, full, empty, level); change detection and the FSM stay in deb_uart_tx.

Verification (bench uses BAUD_DIV=4, FIFO_DEPTH=4)
REQ-031 After reset, deb_in=8'hA5 held -> txd falls 2 edges later; bits 0,1,0,1,0,0,1,0,1 then stop 1, each 4 cycles; one frame only.
REQ-032 deb_in 00->11->22->33 on consecutive cycles -> three frames 8'h11, 8'h22, 8'h33 in order, with exactly one IDLE cycle between frames.
REQ-033 While frame 1 transmits, 6 distinct changes on consecutive cycles -> FIFO fills with the first 4 changes, the remaining 2 are dropped, overflow=1; ovf_clr pulse -> overflow=0.
REQ-034 Full FIFO with a pop and a change on the same edge -> change accepted, level stays 4, overflow stays 0.
REQ-035 reset_n low during the DATA state of a frame -> txd=1 asynchronously, busy=0; after release with deb_in unchanged and nonzero, that value is retransmitted once.
REQ-036 deb_in held constant for 1000 cycles after its frame -> txd stays high, busy=0, no further frames.
